// File: rtl/serial_pkg.sv
// Shared definitions for the serial transmitter/receiver pair: frame formats,
// FSM states and the latched per-frame configuration.
package serial_pkg;

    localparam int unsigned WORD_W    = 8;
    localparam int unsigned TIMER_W   = 4;
    localparam int unsigned BIT_CNT_W = 4;
    localparam int unsigned FUNC_W    = 2;

    localparam logic [FUNC_W-1:0] FMT_NONE  = 2'b00;
    localparam logic [FUNC_W-1:0] FMT_EVEN  = 2'b01;
    localparam logic [FUNC_W-1:0] FMT_ODD   = 2'b10;
    localparam logic [FUNC_W-1:0] FMT_2STOP = 2'b11;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    typedef struct packed {
        logic [FUNC_W-1:0]  func;
        logic [TIMER_W-1:0] m;
    } frame_cfg_t;

endpackage

// File: rtl/bit_timer.sv
// Loadable down-counter; tick marks the last clock of each (period+1)-clock bit.
module bit_timer
    import serial_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic               load,
    input  logic [TIMER_W-1:0] period,
    output logic               tick
);

    logic [TIMER_W-1:0] count;

    assign tick = en && (count == '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (load) begin
            count <= period;
        end else if (en) begin
            count <= tick ? period : count - TIMER_W'(1);
        end
    end

endmodule

// File: rtl/serial_transmitter.sv
// Parallel-to-serial framer: start bit, 8 data bits LSB first, optional parity,
// one or two stop bits, with a valid/ready word input.
module serial_transmitter
    import serial_pkg::*;
#(
    parameter int unsigned WIDTH = WORD_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic [FUNC_W-1:0]  func,
    input  logic [TIMER_W-1:0] m,
    input  logic [WIDTH-1:0]   word_in,
    input  logic               word_valid,
    output logic               word_ready,
    output logic               data_out,
    output logic               busy,
    output logic               done
);

    tx_state_t              state;
    frame_cfg_t             cfg;
    logic [WIDTH-1:0]       shift;
    logic [BIT_CNT_W-1:0]   bit_cnt;
    logic                   stop_cnt;
    logic                   parity_bit;
    logic                   accept;
    logic                   tick;
    logic [TIMER_W-1:0]     period;

    assign accept = enable && word_valid && word_ready && (state == IDLE);
    // A new frame loads the live m; later bits reload from the latched copy.
    assign period = accept ? m : cfg.m;

    bit_timer u_bit_timer (
        .clk    (clk),
        .reset  (reset),
        .en     (enable && (state != IDLE)),
        .load   (accept),
        .period (period),
        .tick   (tick)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cfg        <= '0;
            shift      <= '0;
            bit_cnt    <= '0;
            stop_cnt   <= 1'b0;
            parity_bit <= 1'b0;
            data_out   <= 1'b1;
            word_ready <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else if (!enable) begin
            // Frozen: everything holds, a pending done stays visible until resumed.
            word_ready <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    word_ready <= 1'b1;
                    busy       <= 1'b0;
                    data_out   <= 1'b1;
                    if (accept) begin
                        shift      <= word_in;
                        cfg.func   <= func;
                        cfg.m      <= m;
                        parity_bit <= (func == FMT_ODD) ? ~^word_in : ^word_in;
                        bit_cnt    <= '0;
                        stop_cnt   <= 1'b0;
                        data_out   <= 1'b0;
                        busy       <= 1'b1;
                        word_ready <= 1'b0;
                        state      <= START;
                    end
                end
                START: begin
                    if (tick) begin
                        data_out <= shift[0];
                        state    <= DATA;
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (bit_cnt == BIT_CNT_W'(WIDTH - 1)) begin
                            if ((cfg.func == FMT_EVEN) || (cfg.func == FMT_ODD)) begin
                                data_out <= parity_bit;
                                state    <= PARITY;
                            end else begin
                                data_out <= 1'b1;
                                state    <= STOP;
                            end
                        end else begin
                            bit_cnt  <= bit_cnt + BIT_CNT_W'(1);
                            shift    <= {1'b0, shift[WIDTH-1:1]};
                            data_out <= shift[1];
                        end
                    end
                end
                PARITY: begin
                    if (tick) begin
                        data_out <= 1'b1;
                        state    <= STOP;
                    end
                end
                STOP: begin
                    if (tick) begin
                        if ((cfg.func == FMT_2STOP) && !stop_cnt) begin
                            stop_cnt <= 1'b1;
                        end else begin
                            done       <= 1'b1;
                            busy       <= 1'b0;
                            word_ready <= 1'b1;
                            state      <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_transmitter.sv
// Directed bench for serial_transmitter: frame shape, timing, freeze, reset abort
// and back-to-back streaming decoded from the serial line.
module tb_serial_transmitter;

    logic       clk;
    logic       reset;
    logic       enable;
    logic [1:0] func;
    logic [3:0] m;
    logic [7:0] word_in;
    logic       word_valid;
    logic       word_ready;
    logic       data_out;
    logic       busy;
    logic       done;

    int tests;
    int fails;

    logic line [0:511];
    int   ready_hi;

    serial_transmitter dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .func       (func),
        .m          (m),
        .word_in    (word_in),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .data_out   (data_out),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] decode(input int base, input int p, input int off);
        logic [7:0] w;
        for (int i = 0; i < 8; i++) w[i] = line[base + (1 + i) * p + off];
        return w;
    endfunction

    // Accept one word, record the line until done; returns the frame length.
    task automatic run_frame(input logic [7:0] w, input logic [1:0] f, input logic [3:0] mm,
                             output int len);
        int n;
        func = f; m = mm; word_in = w; word_valid = 1'b1;
        step();
        word_valid = 1'b0;
        n = 0;
        ready_hi = 0;
        while (!done && n < 400) begin
            line[n] = data_out;
            if (word_ready) ready_hi++;
            step();
            n++;
        end
        len = n;
        tests++;
        if (!done) begin
            fails++;
            $display("FAIL frame_timeout word=%h: no done after %0d cycles", w, n);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        step();
        step();
        tests++;
        if (data_out !== 1'b1 || word_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
            fails++;
            $display("FAIL reset_state: data_out=%b ready=%b busy=%b done=%b, want 1 1 0 0",
                     data_out, word_ready, busy, done);
        end
        reset = 1'b1;
        step();
    endtask

    task automatic test_basic();
        int len;
        logic [9:0] got;
        logic [9:0] exp;
        run_frame(8'hA5, 2'b00, 4'd0, len);
        tests++;
        if (len !== 10) begin
            fails++;
            $display("FAIL basic_len: got %0d want 10", len);
        end
        for (int i = 0; i < 10; i++) got[i] = line[i];
        exp = {1'b1, 8'hA5, 1'b0};
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL basic_bits: got %b want %b (bit0 first = rightmost)", got, exp);
        end
        tests++;
        if (ready_hi !== 0) begin
            fails++;
            $display("FAIL basic_ready_busy: word_ready high %0d cycles in frame, want 0", ready_hi);
        end
        tests++;
        if (done !== 1'b1 || word_ready !== 1'b1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL basic_done_cycle: done=%b ready=%b busy=%b want 1 1 0", done, word_ready, busy);
        end
        step();
        tests++;
        if (done !== 1'b0) begin
            fails++;
            $display("FAIL basic_done_pulse: done=%b one cycle later, want 0", done);
        end
    endtask

    task automatic test_parity();
        int len;
        logic [4:0] start_bits;
        run_frame(8'h07, 2'b01, 4'd4, len);
        tests++;
        if (len !== 55) begin
            fails++;
            $display("FAIL even_len: got %0d want 55", len);
        end
        for (int i = 0; i < 5; i++) start_bits[i] = line[i];
        tests++;
        if (start_bits !== 5'b00000 || line[5] !== 1'b1) begin
            fails++;
            $display("FAIL even_period: start=%b first_data=%b want 00000 1", start_bits, line[5]);
        end
        tests++;
        if (decode(0, 5, 2) !== 8'h07) begin
            fails++;
            $display("FAIL even_data: got %h want 07", decode(0, 5, 2));
        end
        tests++;
        if (line[47] !== 1'b1) begin
            fails++;
            $display("FAIL even_parity: got %b want 1", line[47]);
        end
        step();
        run_frame(8'h07, 2'b10, 4'd4, len);
        tests++;
        if (len !== 55 || line[47] !== 1'b0) begin
            fails++;
            $display("FAIL odd_parity: len=%0d parity=%b want 55 0", len, line[47]);
        end
        step();
    endtask

    task automatic test_two_stop();
        int len;
        run_frame(8'hFF, 2'b11, 4'd1, len);
        tests++;
        if (len !== 22) begin
            fails++;
            $display("FAIL two_stop_len: got %0d want 22", len);
        end
        tests++;
        if (line[0] !== 1'b0 || line[1] !== 1'b0 || line[2] !== 1'b1 ||
            line[18] !== 1'b1 || line[21] !== 1'b1) begin
            fails++;
            $display("FAIL two_stop_shape: l0=%b l1=%b l2=%b l18=%b l21=%b want 0 0 1 1 1",
                     line[0], line[1], line[2], line[18], line[21]);
        end
        step();
    endtask

    task automatic test_enable_freeze();
        int n;
        int held_bad;
        logic [7:0] w;
        func = 2'b00; m = 4'd3; word_in = 8'h69; word_valid = 1'b1;
        step();
        word_valid = 1'b0;
        n = 0;
        held_bad = 0;
        while (!done && n < 400) begin
            if (n == 17) begin
                enable = 1'b0;
                word_valid = 1'b1;
                word_in = 8'h00;
                for (int k = 0; k < 7; k++) begin
                    line[n] = data_out;
                    if (data_out !== 1'b1 || word_ready !== 1'b0 || busy !== 1'b1) held_bad++;
                    step();
                    n++;
                end
                enable = 1'b1;
                word_valid = 1'b0;
            end
            line[n] = data_out;
            step();
            n++;
        end
        tests++;
        if (n !== 47) begin
            fails++;
            $display("FAIL freeze_len: got %0d want 47", n);
        end
        tests++;
        if (held_bad !== 0) begin
            fails++;
            $display("FAIL freeze_hold: %0d frozen cycles lost level/ready/busy, want 0", held_bad);
        end
        w = decode(0, 4, 2);
        for (int i = 4; i < 8; i++) w[i] = line[(1 + i) * 4 + 2 + 7];
        tests++;
        if (w !== 8'h69) begin
            fails++;
            $display("FAIL freeze_data: got %h want 69", w);
        end
        // Freeze while idle: a valid word must not start a frame.
        step();
        enable = 1'b0;
        word_in = 8'h12;
        word_valid = 1'b1;
        step();
        step();
        step();
        tests++;
        if (word_ready !== 1'b0 || busy !== 1'b0 || data_out !== 1'b1) begin
            fails++;
            $display("FAIL freeze_idle: ready=%b busy=%b data_out=%b want 0 0 1", word_ready, busy, data_out);
        end
        word_valid = 1'b0;
        enable = 1'b1;
        step();
        step();
        tests++;
        if (word_ready !== 1'b1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL freeze_resume: ready=%b busy=%b want 1 0", word_ready, busy);
        end
    endtask

    task automatic test_reset_mid();
        int len;
        int done_hi;
        func = 2'b00; m = 4'd2; word_in = 8'h3C; word_valid = 1'b1;
        step();
        word_valid = 1'b0;
        for (int i = 0; i < 8; i++) step();
        reset = 1'b0;
        #1;
        tests++;
        if (data_out !== 1'b1 || word_ready !== 1'b1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_abort: data_out=%b ready=%b busy=%b want 1 1 0", data_out, word_ready, busy);
        end
        done_hi = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (done !== 1'b0) done_hi++;
        end
        reset = 1'b1;
        for (int i = 0; i < 15; i++) begin
            step();
            if (done !== 1'b0) done_hi++;
        end
        tests++;
        if (done_hi !== 0) begin
            fails++;
            $display("FAIL reset_no_done: done seen %0d cycles, want 0", done_hi);
        end
        run_frame(8'hC3, 2'b00, 4'd0, len);
        tests++;
        if (len !== 10 || decode(0, 1, 0) !== 8'hC3 || line[0] !== 1'b0) begin
            fails++;
            $display("FAIL reset_next_frame: len=%0d data=%h start=%b want 10 c3 0", len, decode(0, 1, 0), line[0]);
        end
        step();
    endtask

    task automatic test_back_to_back();
        logic [7:0] words [0:2];
        int done_idx [0:2];
        int n;
        int dn;
        int k;
        logic rdy;
        words[0] = 8'h55; words[1] = 8'hAA; words[2] = 8'h3C;
        for (int j = 0; j < 3; j++) done_idx[j] = -1;
        func = 2'b00; m = 4'd1; word_in = words[0]; word_valid = 1'b1;
        step();
        k = 1;
        word_in = words[1];
        n = 0;
        dn = 0;
        while (n < 300) begin
            line[n] = data_out;
            if (done) begin
                done_idx[dn] = n;
                dn++;
                if (dn == 3) break;
            end
            rdy = word_ready;
            step();
            n++;
            if (rdy && word_valid) begin
                k++;
                if (k < 3) word_in = words[k];
                else word_valid = 1'b0;
            end
        end
        word_valid = 1'b0;
        tests++;
        if (done_idx[0] !== 20 || done_idx[1] !== 41 || done_idx[2] !== 62) begin
            fails++;
            $display("FAIL b2b_done_timing: done at %0d %0d %0d want 20 41 62",
                     done_idx[0], done_idx[1], done_idx[2]);
        end
        for (int j = 0; j < 3; j++) begin
            tests++;
            if (decode(21 * j, 2, 1) !== words[j] || line[21 * j] !== 1'b0 || line[21 * j + 1] !== 1'b0) begin
                fails++;
                $display("FAIL b2b_word%0d: got %h start=%b%b want %h start=00",
                         j, decode(21 * j, 2, 1), line[21 * j], line[21 * j + 1], words[j]);
            end
        end
        step();
    endtask

    initial begin
        tests = 0;
        fails = 0;
        reset = 1'b0;
        enable = 1'b1;
        func = 2'b00;
        m = 4'd0;
        word_in = 8'h00;
        word_valid = 1'b0;
        test_reset();
        test_basic();
        test_parity();
        test_two_stop();
        test_enable_freeze();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
